// File: rtl/mux_n_stream_pkg.sv
// Shared constants for the N:1 operand stream multiplexer.
//   MUX_MODE_SEL / MUX_MODE_ARB : encodings of the mode input
//   DEF_WIDTH                   : default channel data width
//   clog2()                     : ceil(log2(v)), used to size select/channel indices
package mux_n_stream_pkg;

   localparam logic MUX_MODE_SEL = 1'b0;
   localparam logic MUX_MODE_ARB = 1'b1;
   localparam int   DEF_WIDTH    = 16;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/mux_n_stream_if.sv
// Handshake bundle for mux_n_stream.
//   in_data/in_valid/in_ready : N_IN producer channels, channel i at [i*WIDTH +: WIDTH]
//   mode/select               : steering controls
//   out_data/out_chan/out_valid/out_ready : registered output stream
// Modports: slave = the multiplexer, master = the environment driving it.
interface mux_n_stream_if
   import mux_n_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_IN  = 4,
   parameter int SEL_W = clog2(N_IN)
);
   logic [N_IN*WIDTH-1:0] in_data;
   logic [N_IN-1:0]       in_valid;
   logic [N_IN-1:0]       in_ready;
   logic                  mode;
   logic [SEL_W-1:0]      select;
   logic [WIDTH-1:0]      out_data;
   logic [SEL_W-1:0]      out_chan;
   logic                  out_valid;
   logic                  out_ready;

   modport slave (
      input  in_data, in_valid, mode, select, out_ready,
      output in_ready, out_data, out_chan, out_valid
   );

   modport master (
      output in_data, in_valid, mode, select, out_ready,
      input  in_ready, out_data, out_chan, out_valid
   );
endinterface

// File: rtl/mux_n_stream_arb.sv
// rr_arbiter: picks one requesting channel.
//   req     : per-channel request
//   ptr     : last granted channel (round-robin build only)
//   gnt     : one-hot grant, all zero when nothing requests
//   gnt_idx : index of the granted channel
// MUX_N_STREAM_RR_EN defined  -> rotating search starting at ptr+1 mod N.
// MUX_N_STREAM_RR_EN undefined -> fixed priority, lowest index wins; ptr unused.
module rr_arbiter
   import mux_n_stream_pkg::*;
#(
   parameter int N     = 4,
   parameter int SEL_W = clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [SEL_W-1:0] gnt_idx
);

`ifdef MUX_N_STREAM_RR_EN
   always_comb begin
      logic found;
      int   idx;
      found   = 1'b0;
      idx     = 0;
      gnt     = '0;
      gnt_idx = '0;
      // offset N wraps back to ptr itself, so the last granted channel is tried last
      for (int k = 1; k <= N; k++) begin
         idx = (int'(ptr) + k) % N;
         if (!found && req[idx]) begin
            found        = 1'b1;
            gnt[idx]     = 1'b1;
            gnt_idx      = SEL_W'(idx);
         end
      end
   end
`else
   logic unused_ptr;
   assign unused_ptr = ^ptr;

   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      // descending scan: the last hit, i.e. the lowest index, wins
      for (int i = N - 1; i >= 0; i--) begin
         if (req[i]) begin
            gnt     = '0;
            gnt[i]  = 1'b1;
            gnt_idx = SEL_W'(i);
         end
      end
   end
`endif

endmodule

// File: rtl/mux_n_stream.sv
// mux_n_stream: N_IN:1 streaming multiplexer with a 1-entry registered output.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : mux_n_stream_if.slave (producer channels, mode/select, output stream)
// mode=0 steers by select (out-of-range select grants nothing); mode=1 arbitrates
// among valid channels. Optional feature macro: MUX_N_STREAM_RR_EN selects
// round-robin arbitration (with a pointer register) instead of fixed priority.
module mux_n_stream
   import mux_n_stream_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int N_IN  = 4,
   parameter int SEL_W = clog2(N_IN)
) (
   input logic             clk,
   input logic             rst_n,
   mux_n_stream_if.slave   bus
);

   logic                  can_load;
   logic                  xfer;
   logic [N_IN-1:0]       onehot;
   logic [N_IN-1:0]       ready;
   logic [N_IN-1:0]       arb_gnt;
   logic [SEL_W-1:0]      arb_idx;
   logic [SEL_W-1:0]      g;
   logic [SEL_W-1:0]      rr_ptr;
   logic [WIDTH-1:0]      sel_data;
   logic [WIDTH-1:0]      data_q;
   logic [SEL_W-1:0]      chan_q;
   logic                  valid_q;

   rr_arbiter #(.N(N_IN), .SEL_W(SEL_W)) u_arb (
      .req     (bus.in_valid),
      .ptr     (rr_ptr),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx)
   );

   always_comb begin
      can_load = !valid_q | bus.out_ready;
      onehot   = '0;
      g        = '0;
      if (bus.mode == MUX_MODE_SEL) begin
         g = bus.select;
         // an out-of-range select matches no channel, leaving the grant empty
         for (int i = 0; i < N_IN; i++)
            onehot[i] = (bus.select == SEL_W'(i));
      end else begin
         g      = arb_idx;
         onehot = arb_gnt;
      end
      ready    = onehot & {N_IN{can_load}};
      xfer     = |(ready & bus.in_valid);
      sel_data = '0;
      for (int i = 0; i < N_IN; i++)
         if (onehot[i]) sel_data = bus.in_data[i*WIDTH +: WIDTH];
   end

   // ready is forced low while reset is held so no producer sees a handshake
   assign bus.in_ready  = ready & {N_IN{rst_n}};
   assign bus.out_data  = data_q;
   assign bus.out_chan  = chan_q;
   assign bus.out_valid = valid_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q <= 1'b0;
         data_q  <= '0;
         chan_q  <= '0;
      end else if (xfer) begin
         valid_q <= 1'b1;
         data_q  <= sel_data;
         chan_q  <= g;
      end else if (bus.out_ready) begin
         valid_q <= 1'b0;
      end
   end

`ifdef MUX_N_STREAM_RR_EN
   // reset to N_IN-1 so the first arbitrated grant starts the search at channel 0
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         rr_ptr <= SEL_W'(N_IN - 1);
      else if (xfer && bus.mode == MUX_MODE_ARB)
         rr_ptr <= g;
   end
`else
   assign rr_ptr = '0;
`endif

endmodule

// File: tb/tb_mux_n_stream.sv
module tb_mux_n_stream;

   logic clk;
   logic rst_n;
   logic rst_b;
   int   checks;
   int   errors;

   mux_n_stream_if #(.WIDTH(16), .N_IN(4)) bus_a ();
   mux_n_stream_if #(.WIDTH(16), .N_IN(3)) bus_b ();

   mux_n_stream #(.WIDTH(16), .N_IN(4)) dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_a.slave)
   );

   mux_n_stream #(.WIDTH(16), .N_IN(3)) dut_b (
      .clk   (clk),
      .rst_n (rst_b),
      .bus   (bus_b.slave)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [15:0] drain_data;
      logic [3:0]  post_rst_ready;
      checks = 0;
      errors = 0;

      // test 1: reset held with every channel valid
      rst_n = 1'b0;
      rst_b = 1'b0;
      for (int i = 0; i < 4; i++) bus_a.in_data[i*16 +: 16] = 16'h1000 + 16'(i);
      bus_a.in_valid  = 4'hF;
      bus_a.mode      = 1'b0;
      bus_a.select    = 2'd0;
      bus_a.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) bus_b.in_data[i*16 +: 16] = 16'h2000 + 16'(i);
      bus_b.in_valid  = 3'b111;
      bus_b.mode      = 1'b0;
      bus_b.select    = 2'd0;
      bus_b.out_ready = 1'b1;
      repeat (2) tick();
      chk("rst_out_valid", bus_a.out_valid, 0);
      chk("rst_in_ready",  bus_a.in_ready,  0);
      chk("rst_out_data",  bus_a.out_data,  0);
      chk("rst_out_chan",  bus_a.out_chan,  0);

      rst_n = 1'b1;
      #1;
      chk("rel_in_ready", bus_a.in_ready, 4'b0001);
      tick();
      chk("first_valid", bus_a.out_valid, 1);
      chk("first_data",  bus_a.out_data,  16'h1000);
      chk("first_chan",  bus_a.out_chan,  0);

      // test 2: external select of ch2
      bus_a.in_data[2*16 +: 16] = 16'hA5A5;
      bus_a.select = 2'd2;
      #1;
      chk("sel2_in_ready", bus_a.in_ready, 4'b0100);
      tick();
      chk("sel2_data",  bus_a.out_data,  16'hA5A5);
      chk("sel2_chan",  bus_a.out_chan,  2);
      chk("sel2_valid", bus_a.out_valid, 1);

      // test 3: backpressure, select changes while the word is held
      bus_a.out_ready = 1'b0;
      #1;
      chk("bp_in_ready", bus_a.in_ready, 0);
      bus_a.select = 2'd1;
      #1;
      chk("bp_sel1_in_ready", bus_a.in_ready, 0);
      tick();
      chk("bp_hold_data",  bus_a.out_data,  16'hA5A5);
      chk("bp_hold_chan",  bus_a.out_chan,  2);
      chk("bp_hold_valid", bus_a.out_valid, 1);
      bus_a.out_ready = 1'b1;
      #1;
      chk("bp_release_in_ready", bus_a.in_ready, 4'b0010);
      tick();
      chk("bp_reload_data", bus_a.out_data, 16'h1001);
      chk("bp_reload_chan", bus_a.out_chan, 1);

      // test 4: arbitrated mode, all channels valid
      bus_a.mode = 1'b1;
      for (int k = 0; k < 8; k++) begin
         tick();
`ifdef MUX_N_STREAM_RR_EN
         chk($sformatf("arb_chan_%0d", k), bus_a.out_chan, k % 4);
`else
         chk($sformatf("arb_chan_%0d", k), bus_a.out_chan, 0);
`endif
         chk($sformatf("arb_valid_%0d", k), bus_a.out_valid, 1);
      end

      // no valid channel in arbitrated mode: nothing granted, register drains
`ifdef MUX_N_STREAM_RR_EN
      drain_data = 16'h1003;
`else
      drain_data = 16'h1000;
`endif
      bus_a.in_valid = 4'h0;
      #1;
      chk("idle_in_ready", bus_a.in_ready, 0);
      tick();
      chk("idle_out_valid", bus_a.out_valid, 0);
      chk("idle_data_hold", bus_a.out_data,  drain_data);

      // test 6: reset mid-stream with a held word
      bus_a.in_valid = 4'hF;
      tick();
      chk("pre_rst_chan",  bus_a.out_chan,  0);
      chk("pre_rst_valid", bus_a.out_valid, 1);
      bus_a.out_ready = 1'b0;
      tick();
      chk("pre_rst_hold", bus_a.out_valid, 1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", bus_a.out_valid, 0);
      chk("mid_rst_data",  bus_a.out_data,  0);
      rst_n = 1'b1;
      bus_a.out_ready = 1'b1;
      #1;
      // the RR pointer was last set to 0; after reset it must point at 3 again
      post_rst_ready = 4'b0001;
      chk("post_rst_in_ready", bus_a.in_ready, post_rst_ready);
      tick();
      chk("post_rst_chan",  bus_a.out_chan,  0);
      chk("post_rst_valid", bus_a.out_valid, 1);

      // test 5: N_IN=3 build, out-of-range select
      rst_b = 1'b1;
      tick();
      chk("n3_load_valid", bus_b.out_valid, 1);
      chk("n3_load_data",  bus_b.out_data,  16'h2000);
      bus_b.select = 2'd3;
      #1;
      chk("n3_oob_in_ready", bus_b.in_ready, 0);
      tick();
      chk("n3_oob_valid", bus_b.out_valid, 0);
      chk("n3_oob_data",  bus_b.out_data,  16'h2000);
      tick();
      chk("n3_oob_stay", bus_b.out_valid, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
